// File: rtl/bdd_walk_engine.sv
// rtl/bdd_walk_engine.sv - BDD evaluator walking a programmable node table one node per cycle
module bdd_walk_engine #(
    parameter int IN_W       = 1894,
    parameter int NODE_DEPTH = 128,
    parameter int IDX_W      = 11,
    parameter int PTR_W      = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_we,
    input  logic [PTR_W-1:0]             cfg_addr,
    input  logic [IDX_W+2*(PTR_W+1)-1:0] cfg_data,
    output logic                         cfg_err,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_W-1:0]              in_vec,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_bit,
    output logic                         out_err,
    output logic                         busy
);

    localparam int CHILD_W = PTR_W + 1;
    localparam int ENTRY_W = IDX_W + 2 * CHILD_W;
    localparam logic [CHILD_W-1:0] TERM0       = {1'b1, {PTR_W{1'b0}}};
    localparam logic [ENTRY_W-1:0] RESET_ENTRY = {{IDX_W{1'b0}}, TERM0, TERM0};
    localparam logic [PTR_W:0]     LAST_STEP   = (PTR_W + 1)'(NODE_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ENTRY_W-1:0] node_tbl [NODE_DEPTH];
    logic [IN_W-1:0]    vec_q;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_next;
    logic [PTR_W:0]     step;
    logic [PTR_W:0]     step_next;
    logic               out_bit_next;
    logic               out_err_next;
    logic               accept;

    logic [ENTRY_W-1:0] node;
    logic [IDX_W-1:0]   node_var;
    logic [CHILD_W-1:0] lo_child;
    logic [CHILD_W-1:0] hi_child;
    logic [CHILD_W-1:0] child;
    logic               bad_idx;

    assign in_ready  = (state == IDLE) && !cfg_we;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Current node is decoded straight from the table registers.
    assign node     = node_tbl[ptr];
    assign node_var = node[ENTRY_W-1 -: IDX_W];
    assign lo_child = node[2*CHILD_W-1 -: CHILD_W];
    assign hi_child = node[CHILD_W-1:0];
    assign bad_idx  = 32'(node_var) >= IN_W;
    assign child    = (!bad_idx && vec_q[node_var]) ? hi_child : lo_child;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        step_next    = step;
        out_bit_next = out_bit;
        out_err_next = out_err;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = WALK;
                    ptr_next   = '0;
                    step_next  = '0;
                end
            end
            WALK: begin
                if (bad_idx) begin
                    out_bit_next = 1'b0;
                    out_err_next = 1'b1;
                    state_next   = DONE;
                end else if (child[PTR_W]) begin
                    out_bit_next = child[0];
                    out_err_next = 1'b0;
                    state_next   = DONE;
                end else if (step == LAST_STEP) begin
                    // Every node visited once without a terminal: the table loops.
                    out_bit_next = 1'b0;
                    out_err_next = 1'b1;
                    state_next   = DONE;
                end else begin
                    ptr_next  = child[PTR_W-1:0];
                    step_next = step + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q   <= '0;
            ptr     <= '0;
            step    <= '0;
            out_bit <= 1'b0;
            out_err <= 1'b0;
            cfg_err <= 1'b0;
            for (int i = 0; i < NODE_DEPTH; i++) begin
                node_tbl[i] <= RESET_ENTRY;
            end
        end else begin
            ptr     <= ptr_next;
            step    <= step_next;
            out_bit <= out_bit_next;
            out_err <= out_err_next;
            cfg_err <= cfg_we && (state != IDLE);
            if (accept) begin
                vec_q <= in_vec;
            end
            // Writes outside IDLE are dropped so a walk never sees the table move.
            if (cfg_we && (state == IDLE)) begin
                node_tbl[cfg_addr] <= cfg_data;
            end
        end
    end

endmodule

// File: tb/tb_bdd_walk_engine.sv
// tb/tb_bdd_walk_engine.sv - randomized self-checking bench for bdd_walk_engine
module tb_bdd_walk_engine;

    localparam int IN_W       = 1894;
    localparam int NODE_DEPTH = 128;
    localparam int IDX_W      = 11;
    localparam int PTR_W      = 7;
    localparam int CW         = PTR_W + 1;
    localparam int EW         = IDX_W + 2 * CW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_we = 1'b0;
    logic [PTR_W-1:0]  cfg_addr = '0;
    logic [EW-1:0]     cfg_data = '0;
    logic              cfg_err;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [IN_W-1:0]   in_vec = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_bit;
    logic              out_err;
    logic              busy;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    bdd_walk_engine #(
        .IN_W(IN_W), .NODE_DEPTH(NODE_DEPTH), .IDX_W(IDX_W), .PTR_W(PTR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_err(cfg_err), .in_valid(in_valid),
        .in_ready(in_ready), .in_vec(in_vec), .out_valid(out_valid),
        .out_ready(out_ready), .out_bit(out_bit), .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s bound expired t=%0t", nm, $time);
    endtask

    function automatic logic [CW-1:0] term(input logic b);
        return {1'b1, {(PTR_W-1){1'b0}}, b};
    endfunction

    function automatic logic [CW-1:0] ptr(input logic [PTR_W-1:0] p);
        return {1'b0, p};
    endfunction

    function automatic logic [EW-1:0] mk(input logic [IDX_W-1:0] v, input logic [CW-1:0] lo,
                                         input logic [CW-1:0] hi);
        return {v, lo, hi};
    endfunction

    // Reference model: table contents plus the pending result and the edge it appears on.
    logic [EW-1:0] m_tbl [NODE_DEPTH];
    bit            m_pending;
    bit            m_cfg_err;
    logic          m_bit;
    logic          m_err;
    int            m_ready;
    int            cyc;
    int            m_k;
    bit            m_done_before;

    function automatic void model_eval(input logic [IN_W-1:0] v, output logic b, output logic e,
                                       output int k);
        int p;
        logic [EW-1:0] ent;
        logic [IDX_W-1:0] vr;
        logic [CW-1:0] ch;
        p = 0;
        for (int s = 0; s < NODE_DEPTH; s++) begin
            ent = m_tbl[p];
            vr  = ent[EW-1 -: IDX_W];
            if (int'(vr) >= IN_W) begin
                b = 1'b0; e = 1'b1; k = s + 1;
                return;
            end
            ch = v[vr] ? ent[CW-1:0] : ent[2*CW-1 -: CW];
            if (ch[CW-1]) begin
                b = ch[0]; e = 1'b0; k = s + 1;
                return;
            end
            p = int'(ch[PTR_W-1:0]);
        end
        b = 1'b0; e = 1'b1; k = NODE_DEPTH;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pending = 1'b0;
            m_cfg_err = 1'b0;
            cyc       = 0;
            m_ready   = 0;
            for (int i = 0; i < NODE_DEPTH; i++) m_tbl[i] = mk('0, term(1'b0), term(1'b0));
        end else begin
            m_done_before = m_pending && (cyc >= m_ready);
            m_cfg_err     = cfg_we && m_pending;
            cyc++;
            if (!m_pending) begin
                if (cfg_we) begin
                    m_tbl[cfg_addr] = cfg_data;
                end else if (in_valid) begin
                    model_eval(in_vec, m_bit, m_err, m_k);
                    m_pending = 1'b1;
                    m_ready   = cyc + m_k;
                end
            end else if (m_done_before && out_ready) begin
                m_pending = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", out_valid, m_pending && (cyc >= m_ready));
            check("in_ready", in_ready, !m_pending && !cfg_we);
            check("busy", busy, m_pending);
            check("cfg_err", cfg_err, m_cfg_err);
            if (m_pending && (cyc >= m_ready)) begin
                check("out_bit", out_bit, m_bit);
                check("out_err", out_err, m_err);
            end
        end
    end

    function automatic logic [IN_W-1:0] rand_vec();
        logic [IN_W-1:0] v;
        for (int i = 0; i < IN_W; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    function automatic logic [CW-1:0] rand_child();
        if ($urandom_range(0, 1) == 0) return term(1'($urandom_range(0, 1)));
        return ptr(PTR_W'($urandom_range(0, 7)));
    endfunction

    function automatic logic [EW-1:0] rand_entry();
        logic [IDX_W-1:0] vr;
        if ($urandom_range(0, 9) == 0) vr = IDX_W'($urandom_range(IN_W, (1 << IDX_W) - 1));
        else vr = IDX_W'($urandom_range(0, IN_W - 1));
        return mk(vr, rand_child(), rand_child());
    endfunction

    task automatic cfg_write(input logic [PTR_W-1:0] a, input logic [EW-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #2;
        cfg_we = 1'b0;
    endtask

    task automatic accept(input logic [IN_W-1:0] v, output bit ok, output int waits);
        in_vec = v; in_valid = 1'b1; ok = 1'b0; waits = 0;
        while (waits < 300) begin
            @(negedge clk); waits++;
            if (in_ready) begin
                @(posedge clk); #2;
                in_valid = 1'b0; ok = 1'b1;
                return;
            end
        end
        in_valid = 1'b0;
        fail_now("accept_timeout");
    endtask

    task automatic run(input logic [IN_W-1:0] v, input bit mid, input int hold,
                       output int waits, output int lat, output logic ob, output logic oe);
        bit ok;
        lat = 0; ob = 1'b0; oe = 1'b0;
        accept(v, ok, waits);
        if (!ok) return;
        if (mid) begin
            cfg_we = 1'b1; cfg_addr = '0; cfg_data = mk('0, term(1'b1), term(1'b1));
        end
        forever begin
            @(posedge clk); lat++; #1;
            if (mid && lat == 1) begin
                check("mid_cfg_err_pulse", cfg_err, 1);
                cfg_we = 1'b0;
            end
            if (out_valid) break;
            if (lat > NODE_DEPTH + 8) begin
                fail_now("result_timeout");
                break;
            end
        end
        ob = out_bit; oe = out_err;
        repeat (hold) begin @(posedge clk); #1; end
        #1 out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
    endtask

    task automatic dir(input string nm, input logic [IN_W-1:0] v, input bit mid, input int hold,
                       input int ek, input logic eb, input logic ee);
        int waits, lat;
        logic ob, oe;
        run(v, mid, hold, waits, lat, ob, oe);
        check({nm, "_latency"}, lat, ek);
        check({nm, "_bit"}, ob, eb);
        check({nm, "_err"}, oe, ee);
    endtask

    initial begin
        logic [IN_W-1:0] v;
        int waits, lat;
        logic ob, oe;
        bit ok;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bit", out_bit, 0);
        check("rst_out_err", out_err, 0);
        check("rst_busy", busy, 0);
        check("rst_cfg_err", cfg_err, 0);
        chk_en = 1'b1;
        #1 rst_n = 1'b1;

        dir("reset_table", rand_vec(), 1'b0, 0, 1, 1'b0, 1'b0);

        cfg_write(0, mk(72, ptr(1), term(1'b1)));
        cfg_write(1, mk(1722, term(1'b0), term(1'b1)));
        v = rand_vec(); v[72] = 1'b0; v[1722] = 1'b1;
        dir("two_node_hi", v, 1'b0, 5, 2, 1'b1, 1'b0);
        v[72] = 1'b1;
        dir("root_terminal", v, 1'b0, 0, 1, 1'b1, 1'b0);
        v[72] = 1'b0; v[1722] = 1'b0;
        dir("two_node_lo", v, 1'b0, 2, 2, 1'b0, 1'b0);

        cfg_write(0, mk(5, ptr(0), ptr(0)));
        dir("loop_mid_cfg", v, 1'b1, 0, NODE_DEPTH, 1'b0, 1'b1);
        dir("loop_table_kept", rand_vec(), 1'b0, 0, NODE_DEPTH, 1'b0, 1'b1);

        cfg_write(0, mk(2000, term(1'b1), term(1'b1)));
        dir("bad_index", v, 1'b0, 0, 1, 1'b0, 1'b1);

        cfg_we = 1'b1; cfg_addr = '0; cfg_data = mk(0, term(1'b1), term(1'b1));
        in_vec = v; in_valid = 1'b1;
        @(negedge clk);
        check("simul_in_ready", in_ready, 0);
        @(posedge clk); #2;
        cfg_we = 1'b0;
        run(v, 1'b0, 0, waits, lat, ob, oe);
        check("simul_accept_wait", waits, 1);
        check("simul_latency", lat, 1);
        check("simul_bit", ob, 1);

        for (int i = 0; i < 5; i++) cfg_write(PTR_W'(i), mk(IDX_W'(i * 100 + 3), ptr(PTR_W'(i + 1)), ptr(PTR_W'(i + 1))));
        cfg_write(5, mk(9, term(1'b0), term(1'b1)));
        v = rand_vec(); v[9] = 1'b1;
        dir("chain6", v, 1'b0, 0, 6, 1'b1, 1'b0);

        accept(v, ok, waits);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("abort_no_valid", out_valid, 0);
            if (i == 2) #1 rst_n = 1'b1;
        end
        #1;
        dir("post_reset", v, 1'b0, 0, 1, 1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                for (int n = 0; n < 6; n++) cfg_write(PTR_W'($urandom_range(0, 7)), rand_entry());
            end
            run(rand_vec(), $urandom_range(0, 3) == 0, $urandom_range(0, 3), waits, lat, ob, oe);
        end

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bdd_walk_engine.md
BDD_WALK_ENGINE -- requirements
Module: bdd_walk_engine

Interface
REQ-001 Parameter IN_W, default 1894, width of the evaluated input vector.
REQ-002 Parameter NODE_DEPTH, default 128, number of programmable BDD node entries.
REQ-003 Parameter IDX_W, default 11, variable-index field width; the block SHALL accept IDX_W >= clog2(IN_W).
REQ-004 Parameter PTR_W, default 7, node-pointer width equal to clog2(NODE_DEPTH).
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 cfg_we  input  1  node-table write strobe.
REQ-008 cfg_addr  input  PTR_W  node index to write.
REQ-009 cfg_data  input  IDX_W+2*(PTR_W+1)  node entry: {var, lo_child, hi_child}, var in the MSBs.
REQ-010 cfg_err  output  1  one-cycle pulse, write dropped.
REQ-011 in_valid  input  1  input vector offered.
REQ-012 in_ready  output  1  engine accepts a vector this cycle.
REQ-013 in_vec  input  IN_W  vector to evaluate.
REQ-014 out_valid  output  1  result available.
REQ-015 out_ready  input  1  consumer takes the result.
REQ-016 out_bit  output  1  evaluated function value.
REQ-017 out_err  output  1  evaluation aborted: loop or bad index.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 Child field encoding: PTR_W+1 bits. MSB=1 means terminal, with the value in bit 0. MSB=0 means a pointer to a node, held in the low PTR_W bits.
REQ-020 Node semantics: the walk follows hi_child when in_vec[var]=1 and lo_child otherwise. The root is always node 0.
REQ-021 The FSM SHALL have states IDLE, WALK and DONE.
REQ-022 in_ready SHALL be high when state=IDLE and cfg_we=0.
REQ-023 IDLE -> WALK on in_valid and in_ready. On that transition the block SHALL latch in_vec, set ptr=0 and set step=0.
REQ-024 WALK SHALL evaluate exactly one node per cycle, read combinationally from the node-table registers.
REQ-025 If the selected child is terminal: out_bit=child[0], out_err=0, go to DONE.
REQ-026 If the selected child is not terminal: ptr=child[PTR_W-1:0], step=step+1, stay in WALK.
REQ-027 Bad index: if the current node's var >= IN_W, the block SHALL set out_err=1 and out_bit=0 and go to DONE.
REQ-028 Loop guard: when step=NODE_DEPTH-1 and the selected child is not terminal, the block SHALL set out_err=1 and out_bit=0 and go to DONE.
REQ-029 Latency: a path that visits k nodes SHALL assert out_valid on the k-th rising edge after the acceptance edge, for 1 <= k <= NODE_DEPTH.
REQ-030 In DONE, out_valid=1. out_bit and out_err SHALL stay stable until out_ready=1, and DONE -> IDLE then follows on that edge.
REQ-031 A new vector SHALL NOT be accepted on the same edge that leaves DONE, giving a minimum of 1 IDLE cycle between results.
REQ-032 Config writes SHALL take effect on the clock edge only in IDLE.
REQ-033 Simultaneous cfg_we and in_valid in IDLE: the write SHALL take effect and the vector SHALL NOT be accepted that cycle.
REQ-034 A cfg_we in WALK or DONE SHALL be dropped and SHALL pulse cfg_err for one cycle. An in-flight walk SHALL never observe a table change.
REQ-035 The step counter SHALL be PTR_W+1 bits wide and SHALL never wrap during a walk.

Reset
REQ-036 While rst_n=0 the outputs SHALL be state=IDLE, in_ready=1, out_valid=0, out_bit=0, out_err=0, busy=0 and cfg_err=0.
REQ-037 Reset SHALL set every node entry to var=0, lo_child=hi_child=terminal-0. A vector accepted after reset therefore returns out_bit=0 with k=1.
REQ-038 Reset asserted mid-walk or in DONE SHALL abort the walk with no result delivered. The first post-reset result SHALL come from a newly accepted vector.

Verification
REQ-039 Reset, then offer any vector -> out_valid 1 cycle after acceptance, out_bit=0, out_err=0.
REQ-040 Program node0={var 72, lo ptr1, hi terminal-1} and node1={var 1722, lo terminal-0, hi terminal-1}.
- Vector with bit72=0 and bit1722=1 -> out_bit=1 after 2 cycles.
- Vector with bit72=1 -> out_bit=1 after 1 cycle.
REQ-041 Program node0={var 5, lo ptr0, hi ptr0}, then offer a vector -> out_err=1, out_bit=0, out_valid exactly NODE_DEPTH cycles after acceptance.
REQ-042 Program node0.var=2000 with IN_W=1894 -> out_err=1 after 1 cycle.
REQ-043 Handshake and config checks:
- Hold out_ready=0 for 5 cycles -> out_bit, out_err and out_valid stable, in_ready=0.
- cfg_we during WALK -> cfg_err pulse, table unchanged.
- cfg_we with in_valid in IDLE -> write applied, vector accepted the next cycle.
REQ-044 Assert rst_n=0 at step 3 of a 6-node walk -> no out_valid. A re-offered vector after reset returns 0 after 1 cycle.
